// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle sequencing controller for the MIPS-style core: one FSM pass per
// instruction (FETCH/DECODE/EXEC/MEM/WB) with a datamem wait-state handshake.
module multicycle_seq_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             regdst,
    output logic             regorimm,
    output logic             aluormem,
    output logic [2:0]       aluop,
    output logic             memread,
    output logic             memwrite,
    output logic             regw,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [5:0]        op_q;
    logic [WAIT_W-1:0] wait_q;
    logic              illegal_q, mem_err_q;
    logic [CNT_W-1:0]  retired_q;
    logic              retire, mem_timeout, is_load, is_store;

    assign is_load  = (op_q == 6'd8);
    assign is_store = (op_q == 6'd9);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
                if (opcode > 6'd11) illegal_q <= 1'b1;
            end
            if (mem_timeout) mem_err_q <= 1'b1;
            wait_q <= (state_q == S_MEM && !mem_ready && !mem_timeout) ? wait_q + 1'b1 : '0;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'd0;
        regdst      = 1'b0;
        regorimm    = 1'b0;
        aluormem    = 1'b0;
        aluop       = 3'b000;
        memread     = 1'b0;
        memwrite    = 1'b0;
        regw        = 1'b0;
        retire      = 1'b0;
        mem_timeout = 1'b0;

        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            case (op_q)
                6'd0, 6'd1, 6'd2, 6'd3: regdst = 1'b1;
                6'd4: begin regorimm = 1'b1; aluop = 3'b001; end
                6'd5: begin regorimm = 1'b1; aluop = 3'b010; end
                6'd6: begin regorimm = 1'b1; aluop = 3'b100; end
                6'd7: begin regorimm = 1'b1; aluop = 3'b101; end
                6'd8, 6'd9: begin regorimm = 1'b1; aluormem = 1'b1; aluop = 3'b011; end
                6'd10: aluop = 3'b110;
                6'd11: aluop = 3'b111;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH: begin
                ir_we   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: state_d = (opcode > 6'd11) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (op_q <= 6'd7) begin
                    state_d = S_WB;
                end else if (op_q <= 6'd9) begin
                    state_d = S_MEM;
                end else begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                    pc_src = (op_q == 6'd11) ? 2'd2 : (zero ? 2'd1 : 2'd0);
                end
            end
            S_MEM: begin
                // The store's PC update shares the completing write cycle;
                // the strobe must stay up until the access is acknowledged.
                memread  = is_load;
                memwrite = is_store;
                if (mem_ready) begin
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    mem_timeout = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_WB: begin
                regw   = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase

        if (retire) state_d = run ? S_FETCH : S_IDLE;
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign mem_err = mem_err_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Scoreboard bench for multicycle_seq_ctrl: the driver pushes per-instruction
// expectations from a table model; a negedge monitor pops them on each retire.
module tb_multicycle_seq_ctrl;
    localparam int CNT_W = 8;   // narrow counter keeps the wrap test short

    logic             clk = 1'b0;
    logic             rst, run, zero, mem_ready;
    logic [5:0]       opcode;
    logic             ir_we, pc_we, regdst, regorimm, aluormem, memread, memwrite, regw;
    logic             illegal, mem_err;
    logic [1:0]       pc_src;
    logic [2:0]       aluop, state;
    logic [CNT_W-1:0] retired;

    multicycle_seq_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .regdst(regdst), .regorimm(regorimm), .aluormem(aluormem), .aluop(aluop),
        .memread(memread), .memwrite(memwrite), .regw(regw), .state(state),
        .illegal(illegal), .mem_err(mem_err), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               lat;
        logic [1:0]       pc_src;
        logic [2:0]       aluop;
        logic             regdst, regorimm, aluormem;
        int               n_regw, n_rd, n_wr;
        logic [CNT_W-1:0] retired;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_ret = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected behaviour of one instruction, straight from the opcode table.
    function automatic exp_t model(input logic [5:0] op, input logic z, input int waits);
        exp_t e;
        e = '{lat: 4, pc_src: 2'd0, aluop: 3'b000, regdst: 1'b0, regorimm: 1'b0,
              aluormem: 1'b0, n_regw: 1, n_rd: 0, n_wr: 0, retired: '0};
        case (op)
            6'd0, 6'd1, 6'd2, 6'd3: e.regdst = 1'b1;
            6'd4: begin e.regorimm = 1'b1; e.aluop = 3'b001; end
            6'd5: begin e.regorimm = 1'b1; e.aluop = 3'b010; end
            6'd6: begin e.regorimm = 1'b1; e.aluop = 3'b100; end
            6'd7: begin e.regorimm = 1'b1; e.aluop = 3'b101; end
            6'd8: begin
                e.regorimm = 1'b1; e.aluormem = 1'b1; e.aluop = 3'b011;
                e.n_rd = waits + 1; e.lat = 5 + waits;
            end
            6'd9: begin
                e.regorimm = 1'b1; e.aluormem = 1'b1; e.aluop = 3'b011;
                e.n_wr = waits + 1; e.lat = 4 + waits; e.n_regw = 0;
            end
            6'd10: begin e.aluop = 3'b110; e.pc_src = z ? 2'd1 : 2'd0; e.lat = 3; e.n_regw = 0; end
            default: begin e.aluop = 3'b111; e.pc_src = 2'd2; e.lat = 3; e.n_regw = 0; end
        endcase
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int guard = 0;
        while (state !== s && guard < 20) begin step(); guard++; end
        if (state !== s) check(name, {29'd0, state}, {29'd0, s});
    endtask

    // Drives one instruction from FETCH to retire, answering MEM after `waits` cycles.
    task automatic run_instr(input logic [5:0] op, input logic z, input int waits, input logic run_after);
        exp_t e;
        int   mcnt = 0;
        int   guard = 0;
        logic done = 1'b0;
        wait_state(3'd1, "fetch_wait");
        if (state !== 3'd1) return;
        opcode    = op;
        zero      = z;
        mem_ready = 1'b0;
        e         = model(op, z, waits);
        e.retired = exp_ret[CNT_W-1:0];
        exp_q.push_back(e);
        exp_ret = (exp_ret + 1) % (1 << CNT_W);
        while (!done && guard < 40) begin
            if (state == 3'd3) run = run_after;
            if (state == 3'd4) begin
                mem_ready = (mcnt == waits);
                mcnt++;
            end else begin
                mem_ready = 1'b0;
            end
            #1;
            done = pc_we;
            step();
            guard++;
        end
        mem_ready = 1'b0;
        if (!done) check("retire_wait", 0, 1);
        check("next_state", {29'd0, state}, run_after ? 32'd1 : 32'd0);
    endtask

    // Monitor: accumulates strobes per instruction and compares at each retire.
    int   m_cyc, m_rd, m_wr, m_rw;
    logic m_clash;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst || ir_we) begin
                m_cyc = 0; m_rd = 0; m_wr = 0; m_rw = 0; m_clash = 1'b0;
            end
            if (!rst) begin
                m_cyc++;
                m_rd += int'(memread);
                m_wr += int'(memwrite);
                m_rw += int'(regw);
                if (memwrite && (regw || ir_we || (pc_we && !mem_ready))) m_clash = 1'b1;
                if (pc_we) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_retire", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("latency", m_cyc, e.lat);
                        check("pc_src", {30'd0, pc_src}, {30'd0, e.pc_src});
                        check("aluop", {29'd0, aluop}, {29'd0, e.aluop});
                        check("steer", {29'd0, regdst, regorimm, aluormem},
                              {29'd0, e.regdst, e.regorimm, e.aluormem});
                        check("regw_cycles", m_rw, e.n_regw);
                        check("memread_cycles", m_rd, e.n_rd);
                        check("memwrite_cycles", m_wr, e.n_wr);
                        check("retired", {24'd0, retired}, {24'd0, e.retired});
                        check("strobe_clash", {31'd0, m_clash}, 0);
                    end
                end
            end
        end
    end

    task automatic check_quiet(input string name, input logic [2:0] s);
        check(name, {24'd0, ir_we, pc_we, regw, memread, memwrite, state},
              {29'd0, s});
    endtask

    initial begin
        int   n, guard;
        logic ra;
        rst = 1'b1; run = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
        step(); step();
        check_quiet("reset_state", 3'd0);
        check("reset_aluop_pcsrc", {27'd0, aluop, pc_src}, 0);
        check("reset_flags", {30'd0, illegal, mem_err}, 0);
        check("reset_retired", {24'd0, retired}, 0);
        rst = 1'b0;

        repeat (3) run_instr(6'd0, 1'b0, 0, 1'b1);
        run_instr(6'd8, 1'b0, 3, 1'b1);
        run_instr(6'd10, 1'b1, 0, 1'b1);
        run_instr(6'd10, 1'b0, 0, 1'b1);
        run_instr(6'd11, 1'b0, 0, 1'b1);
        run_instr(6'd9, 1'b0, 2, 1'b1);
        run_instr(6'd5, 1'b0, 0, 1'b0);
        run = 1'b1;

        for (int i = 0; i < 150; i++) begin
            ra = ($urandom_range(0, 7) != 0);
            run_instr(6'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 4), ra);
            run = 1'b1;
        end
        for (int i = 0; i < 300; i++) run_instr(6'd11, 1'($urandom_range(0, 1)), 0, 1'b1);

        // Reset in the middle of a stalled load.
        wait_state(3'd1, "fetch_wait");
        opcode = 6'd8; mem_ready = 1'b0;
        wait_state(3'd4, "mem_wait");
        repeat (5) step();
        rst = 1'b1;
        step();
        check_quiet("rst_in_mem", 3'd0);
        check("rst_in_mem_retired", {24'd0, retired}, 0);
        rst = 1'b0; exp_ret = 0;

        // Store that never completes must time out after 15 MEM cycles.
        wait_state(3'd1, "fetch_wait");
        opcode = 6'd9; mem_ready = 1'b0;
        wait_state(3'd4, "mem_wait");
        n = 0; guard = 0;
        while (state == 3'd4 && guard < 40) begin n += int'(memwrite); step(); guard++; end
        check("timeout_memwrite_cycles", n, 15);
        check_quiet("timeout_halt", 3'd6);
        check("timeout_flags", {30'd0, illegal, mem_err}, 32'd1);
        repeat (3) begin step(); check_quiet("halt_sticky", 3'd6); end

        rst = 1'b1; step(); step(); rst = 1'b0;
        check("reset_clears_mem_err", {31'd0, mem_err}, 0);

        // Illegal opcode halts in DECODE.
        wait_state(3'd1, "fetch_wait");
        opcode = 6'($urandom_range(12, 63));
        step(); step();
        check_quiet("illegal_halt", 3'd6);
        check("illegal_flags", {30'd0, illegal, mem_err}, 32'd2);
        repeat (3) begin step(); check_quiet("illegal_sticky", 3'd6); end

        rst = 1'b1; step(); step(); rst = 1'b0;
        check("reset_clears_illegal", {31'd0, illegal}, 0);
        run_instr(6'd4, 1'b0, 0, 1'b0);

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin step(); guard++; end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
